// File: rtl/conf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conf_pkg                                                  |
// | Brief    : Shared constants for the configuration-stream loader:     |
// |            FSM state encoding and the broadcast tile address.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package conf_pkg;

  // Width of the loader state register
  localparam int unsigned c_state_w = 2;

  // Loader FSM state encoding
  localparam logic [c_state_w-1:0] c_st_idle   = 2'd0;
  localparam logic [c_state_w-1:0] c_st_load   = 2'd1;
  localparam logic [c_state_w-1:0] c_st_skip   = 2'd2;
  localparam logic [c_state_w-1:0] c_st_commit = 2'd3;

  // Broadcast address is "all ones" in the header ID field. It is kept wide
  // here and sliced down to the ID width by each loader instance.
  localparam logic [63:0] c_bcast_all = '1;

endpackage : conf_pkg
`default_nettype wire

// File: rtl/conf_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conf_loader                                               |
// | Brief    : Per-tile configuration loader. Consumes a word stream of  |
// |            frames (header + NWORDS payload words), collects frames   |
// |            addressed to this tile (or broadcast) into a shadow       |
// |            register and commits them atomically to conf.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module conf_loader
  import conf_pkg::*;
#(
  parameter int WORD      = 8,
  parameter int CONF_BITS = 64,
  parameter int TILE_ID   = 0,
  parameter int NWORDS    = (CONF_BITS + WORD - 1) / WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [CONF_BITS-1:0] conf,
  output logic                 cset,
  output logic                 busy,
  output logic                 err
);

  // Payload word counter must be able to hold NWORDS itself
  localparam int c_cnt_w = (NWORDS < 1) ? 1 : $clog2(NWORDS + 1);

  // Number of stream words actually needed to cover the conf register
  localparam int c_used_words = (CONF_BITS + WORD - 1) / WORD;

  // Header ID field constants, sized to the WORD-1 bit ID field
  localparam logic [WORD-2:0] c_tile_id  = (WORD-1)'(TILE_ID);
  localparam logic [WORD-2:0] c_bcast_id = c_bcast_all[WORD-2:0];

  // Counter value of the final payload word in a frame
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(NWORDS - 1);

  // ------------------------------------------------------------------
  // Declarations
  // ------------------------------------------------------------------
  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_next_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [CONF_BITS-1:0] w_shadow;
  logic [CONF_BITS-1:0] r_conf;
  logic                 r_cset;
  logic                 r_err;

  logic                 w_ready;
  logic                 w_busy;
  logic                 w_accept;
  logic                 w_hdr_accept;
  logic                 w_load_accept;
  logic                 w_skip_accept;
  logic                 w_last_word;
  logic [WORD-2:0]      w_hdr_id;
  logic                 w_hdr_rsvd;
  logic                 w_hdr_match;

  // ------------------------------------------------------------------
  // Handshake and header decode
  // ------------------------------------------------------------------
  assign w_accept      = in_valid & w_ready;
  assign w_hdr_accept  = w_accept & (r_state == c_st_idle);
  assign w_load_accept = w_accept & (r_state == c_st_load);
  assign w_skip_accept = w_accept & (r_state == c_st_skip);
  assign w_last_word   = (r_cnt == c_last_cnt);

  assign w_hdr_id      = in_data[WORD-2:0];
  assign w_hdr_rsvd    = in_data[WORD-1];
  assign w_hdr_match   = (w_hdr_id == c_tile_id) || (w_hdr_id == c_bcast_id);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  // Hold current loader state; reset always returns to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  // Header routes to LOAD/SKIP; the last payload word ends the frame
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          // A reserved-bit header is never trusted, even if its ID matches
          if (w_hdr_rsvd) begin
            w_next_state = c_st_skip;
          end else if (w_hdr_match) begin
            w_next_state = c_st_load;
          end else begin
            w_next_state = c_st_skip;
          end
        end
      end
      c_st_load: begin
        if (w_accept && w_last_word) begin
          w_next_state = c_st_commit;
        end
      end
      c_st_skip: begin
        if (w_accept && w_last_word) begin
          w_next_state = c_st_idle;
        end
      end
      c_st_commit: begin
        w_next_state = c_st_idle;
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ------------------------------------------------------------------
  // Ready and busy are pure functions of state, so no in_valid->in_ready path
  always_comb begin
    w_ready = 1'b1;
    w_busy  = 1'b1;
    case (r_state)
      c_st_idle: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
      c_st_load, c_st_skip: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
      end
      c_st_commit: begin
        w_ready = 1'b0;
        w_busy  = 1'b1;
      end
      default: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Payload word counter
  // ------------------------------------------------------------------
  // Restart at every header, advance on each accepted payload word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_hdr_accept) begin
      r_cnt <= '0;
    end else if (w_load_accept || w_skip_accept) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // ------------------------------------------------------------------
  // Shadow register, one slice per payload word
  // ------------------------------------------------------------------
  // The final slice may be narrower than WORD; the excess payload bits of
  // that word are simply never stored.
  for (genvar k = 0; k < c_used_words; k++) begin : g_shadow_word
    localparam int  c_lo   = k * WORD;
    localparam int  c_hi   = ((k + 1) * WORD > CONF_BITS) ? (CONF_BITS - 1)
                                                          : ((k + 1) * WORD - 1);
    localparam int  c_w    = c_hi - c_lo + 1;
    localparam bit  c_live = (k < NWORDS);

    logic [c_w-1:0] r_part;

    // Capture payload word k while loading a frame addressed to this tile
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_part <= '0;
      end else if (c_live && w_load_accept && (r_cnt == c_cnt_w'(k))) begin
        r_part <= in_data[c_w-1:0];
      end
    end

    assign w_shadow[c_hi:c_lo] = r_part;
  end

  // ------------------------------------------------------------------
  // Committed configuration and strobe
  // ------------------------------------------------------------------
  // conf only moves in COMMIT, so partial or foreign frames never show up
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conf <= '0;
    end else if (r_state == c_st_commit) begin
      r_conf <= w_shadow;
    end
  end

  // Strobe lands in the same cycle the new conf value first appears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cset <= 1'b0;
    end else begin
      r_cset <= (r_state == c_st_commit);
    end
  end

  // Sticky flag for a header carrying the reserved top bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_hdr_accept && w_hdr_rsvd) begin
      r_err <= 1'b1;
    end
  end

  assign in_ready = w_ready;
  assign busy     = w_busy;
  assign conf     = r_conf;
  assign cset     = r_cset;
  assign err      = r_err;

endmodule : conf_loader
`default_nettype wire
